hex_ascii_streamer: RTL and testbench

- Parametrised successor to the single-nibble hex-to-ASCII converter used on the character-LCD path.
- Accepts a DATA_WIDTH-bit value over a valid/ready handshake and emits its hex digits MSB-first as ASCII bytes, one per accepted output beat.
- Sits between datapath debug taps (PC, register values, ALU result) and the LCD write controller.
- Handles back-pressure from the LCD controller.

---
 rtl/hex_ascii_streamer.sv | 106 ++++++++++
 tb/tb_hex_ascii_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_ascii_streamer.sv
// Streams a DATA_WIDTH value as MSB-first hex ASCII chars.
// Optional leading-zero blanking: define HEX_ASCII_LEADING_BLANK_EN.
module hex_ascii_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int UPPERCASE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data,
  output logic                  char_last,
  output logic                  busy
);

  localparam int NUM_DIGITS = DATA_WIDTH / 4;
  localparam int CW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(NUM_DIGITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  if (DATA_WIDTH < 4 || DATA_WIDTH > 32 ||
      (DATA_WIDTH % 4) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be 4..32, multiple of 4");
  end

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0]         cnt;
  logic [3:0]            nib;
  logic [7:0]            glyph;
  logic                  sending;
  logic                  blank;
  logic                  in_fire;
  logic                  out_fire;

  assign nib     = sr[DATA_WIDTH-1 -: 4];
  assign sending = (state == SEND) & ~reset;

  assign in_ready   = (state == IDLE) & ~reset;
  assign char_valid = sending;
  assign busy       = sending;
  assign char_last  = sending & (cnt == '0);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = char_valid & char_ready;

  // Nibble to ASCII glyph, case chosen by UPPERCASE
  always_comb begin
    glyph = 8'h30;
    if (nib < 4'd10)
      glyph = 8'h30 + {4'h0, nib};
    else if (UPPERCASE != 0)
      glyph = 8'h37 + {4'h0, nib};
    else
      glyph = 8'h57 + {4'h0, nib};
  end

`ifdef HEX_ASCII_LEADING_BLANK_EN
  logic lead;

  assign blank = lead & (nib == 4'h0) & (cnt != '0);

  // Leading-zero flag: set on load, cleared by first nonzero digit
  always_ff @(posedge clk) begin
    if (reset)
      lead <= 1'b0;
    else if (in_fire)
      lead <= 1'b1;
    else if (out_fire && nib != 4'h0)
      lead <= 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  assign char_data = reset ? 8'h30 :
                     blank ? 8'h20 : glyph;

  // IDLE/SEND sequencing with shift register and digit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (in_fire) begin
      sr    <= in_data;
      cnt   <= CNT_LOAD;
      state <= SEND;
    end else if (out_fire) begin
      if (cnt == '0) begin
        state <= IDLE;
      end else begin
        sr  <= sr << 4;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer.
// Expected chars follow HEX_ASCII_LEADING_BLANK_EN if defined.
module tb_hex_ascii_streamer;

`ifdef HEX_ASCII_LEADING_BLANK_EN
  localparam logic [7:0] Z = 8'h20;
`else
  localparam logic [7:0] Z = 8'h30;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        char_ready;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_last;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  in_data1;
  logic        char_valid1;
  logic [7:0]  char_data1;
  logic        char_last1;
  logic        busy1;

  logic        in_valid2;
  logic        in_ready2;
  logic [3:0]  in_data2;
  logic        char_valid2;
  logic [7:0]  char_data2;
  logic        char_last2;
  logic        busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_ascii_streamer #(
    .DATA_WIDTH(16),
    .UPPERCASE(1)
  ) u0 (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_data(char_data),
    .char_last(char_last),
    .busy(busy)
  );

  hex_ascii_streamer #(
    .DATA_WIDTH(8),
    .UPPERCASE(0)
  ) u1 (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid1),
    .in_ready(in_ready1),
    .in_data(in_data1),
    .char_valid(char_valid1),
    .char_ready(char_ready),
    .char_data(char_data1),
    .char_last(char_last1),
    .busy(busy1)
  );

  hex_ascii_streamer #(
    .DATA_WIDTH(4),
    .UPPERCASE(1)
  ) u2 (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid2),
    .in_ready(in_ready2),
    .in_data(in_data2),
    .char_valid(char_valid2),
    .char_ready(char_ready),
    .char_data(char_data2),
    .char_last(char_last2),
    .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chr(input string tag,
                     input logic [7:0] d,
                     input logic l);
    chk({tag, "_valid"}, 32'(char_valid), 32'd1);
    chk({tag, "_data"}, 32'(char_data), 32'(d));
    chk({tag, "_last"}, 32'(char_last), 32'(l));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic idle(input string tag);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid"}, 32'(char_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic stream4(input string tag,
                         input logic [15:0] d,
                         input logic [7:0] e0,
                         input logic [7:0] e1,
                         input logic [7:0] e2,
                         input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chr($sformatf("%s_c%0d", tag, i), e[i], i == 3);
      tick();
    end
    idle({tag, "_end"});
  endtask

  initial begin
    reset      = 1'b1;
    char_ready = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    in_valid2  = 1'b0;
    in_data2   = '0;

    tick();
    tick();
    chk("rst_inrdy", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(char_last), 32'd0);
    chk("rst_data", 32'(char_data), 32'h30);

    reset = 1'b0;
    #1;
    idle("rel");

    // Plain stream
    stream4("plain", 16'h1A3F,
            8'h31, 8'h41, 8'h33, 8'h46);

    // Back-pressure on second character
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    chr("bp_c0", 8'h42, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      char_ready = 1'b0;
      #1;
      chr($sformatf("bp_hold%0d", i), 8'h45, 1'b0);
      tick();
    end
    char_ready = 1'b1;
    chr("bp_c1", 8'h45, 1'b0);
    tick();
    chr("bp_c2", 8'h45, 1'b0);
    tick();
    chr("bp_c3", 8'h46, 1'b1);
    tick();
    idle("bp_end");

    // Lowercase 8-bit instance
    chk("lc_pre", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1;
    in_data1  = 8'hC9;
    tick();
    in_valid1 = 1'b0;
    chk("lc_c0", 32'(char_data1), 32'h63);
    chk("lc_l0", 32'(char_last1), 32'd0);
    chk("lc_v0", 32'(char_valid1), 32'd1);
    tick();
    chk("lc_c1", 32'(char_data1), 32'h39);
    chk("lc_l1", 32'(char_last1), 32'd1);
    tick();
    chk("lc_end_v", 32'(char_valid1), 32'd0);
    chk("lc_end_r", 32'(in_ready1), 32'd1);

    // 4-bit instance: single char, always last
    in_valid2 = 1'b1;
    in_data2  = 4'hE;
    tick();
    in_valid2 = 1'b0;
    chk("w4_data", 32'(char_data2), 32'h45);
    chk("w4_last", 32'(char_last2), 32'd1);
    chk("w4_valid", 32'(char_valid2), 32'd1);
    tick();
    chk("w4_end", 32'(in_ready2), 32'd1);

    // Mid-stream reset after two characters
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    chr("mr_c0", 8'h31, 1'b0);
    tick();
    chr("mr_c1", 8'h32, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_rst_valid", 32'(char_valid), 32'd0);
    chk("mr_rst_inrdy", 32'(in_ready), 32'd0);
    chk("mr_rst_data", 32'(char_data), 32'h30);
    tick();
    reset = 1'b0;
    #1;
    idle("mr_after");
    tick();
    idle("mr_after2");
    stream4("mr_next", 16'h00FF,
            Z, Z, 8'h46, 8'h46);

    // Reset together with input handshake
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5678;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    idle("rh_a");
    tick();
    idle("rh_b");

    // Back-to-back inputs with in_valid held
    in_valid = 1'b1;
    in_data  = 16'h0001;
    tick();
    in_data = 16'hFFFF;
    chr("bb_a0", Z, 1'b0);
    tick();
    chr("bb_a1", Z, 1'b0);
    tick();
    chr("bb_a2", Z, 1'b0);
    tick();
    chr("bb_a3", 8'h31, 1'b1);
    tick();
    chk("bb_gap_rdy", 32'(in_ready), 32'd1);
    chk("bb_gap_v", 32'(char_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chr($sformatf("bb_b%0d", i), 8'h46, i == 3);
      tick();
    end
    idle("bb_end");

    // Leading-zero patterns
    stream4("z_a5", 16'h00A5,
            Z, Z, 8'h41, 8'h35);
    stream4("z_00", 16'h0000,
            Z, Z, Z, 8'h30);
    stream4("z_100", 16'h0100,
            Z, 8'h31, 8'h30, 8'h30);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
